// File: rtl/sevseg_pkg.sv
// Shared types and constants for the 7-segment scan controller and its decoder.
package sevseg_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [6:0] SEG_OFF   = 7'b1111111;
  localparam logic [3:0] AN_OFF    = 4'b1111;

endpackage

// File: rtl/bcd_to_sevseg.sv
// Combinational BCD to common-anode 7-segment decoder, {g,f,e,d,c,b,a} active-low.
module bcd_to_sevseg
  import sevseg_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Codes A-F are not digits, so they light nothing.
  always_comb begin
    seg_o = SEG_OFF;
    case (bcd_i)
      4'd0: seg_o = 7'b1000000;
      4'd1: seg_o = 7'b1111001;
      4'd2: seg_o = 7'b0100100;
      4'd3: seg_o = 7'b0110000;
      4'd4: seg_o = 7'b0011001;
      4'd5: seg_o = 7'b0010010;
      4'd6: seg_o = 7'b0000010;
      4'd7: seg_o = 7'b1111000;
      4'd8: seg_o = 7'b0000000;
      4'd9: seg_o = 7'b0010000;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/sevseg_scan_ctrl.sv
// Double-buffered 4-digit 7-segment scan controller with inter-digit blanking.
// Optional leading-zero suppression is enabled by defining LEADING_ZERO_BLANK_EN.
module sevseg_scan_ctrl
  import sevseg_pkg::*;
#(
  parameter int unsigned SHOW_CYC  = 100000,
  parameter int unsigned BLANK_CYC = 1000,
  parameter int unsigned CNT_W     = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  output logic [3:0]  anN,
  output logic [6:0]  segN,
  output logic        dpN,
  output logic        frame_tick
);

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYC - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  state_t           state_q;
  logic [1:0]       idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic [15:0]      pend_q;
  logic [3:0]       pend_dp_q;
  logic [15:0]      act_q;
  logic [3:0]       act_dp_q;
  logic [3:0]       an_q;
  logic [3:0]       nib_q;
  logic             dpn_q;
  logic             tick_q;
  logic [3:0]       show_nib_d;

`ifdef LEADING_ZERO_BLANK_EN
  logic [3:0] lead_zero;

  // A digit is a leading zero when it and every digit to its left are zero.
  always_comb begin
    lead_zero    = 4'b0000;
    lead_zero[3] = (act_q[15:12] == 4'd0);
    lead_zero[2] = lead_zero[3] && (act_q[11:8] == 4'd0);
    lead_zero[1] = lead_zero[2] && (act_q[7:4] == 4'd0);
    show_nib_d   = lead_zero[idx_q] ? BCD_BLANK : act_q[{idx_q, 2'b00} +: 4];
  end
`else
  assign show_nib_d = act_q[{idx_q, 2'b00} +: 4];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_BLANK;
      idx_q     <= 2'd0;
      cnt_q     <= '0;
      pend_q    <= 16'hFFFF;
      pend_dp_q <= 4'b0000;
      act_q     <= 16'hFFFF;
      act_dp_q  <= 4'b0000;
      an_q      <= AN_OFF;
      nib_q     <= BCD_BLANK;
      dpn_q     <= 1'b1;
      tick_q    <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (load) begin
        pend_q    <= digits_in;
        pend_dp_q <= dp_in;
      end
      case (state_q)
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_q <= ST_SHOW;
            cnt_q   <= '0;
            an_q    <= ~(4'b0001 << idx_q);
            nib_q   <= show_nib_d;
            dpn_q   <= ~act_dp_q[idx_q];
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            state_q <= ST_BLANK;
            cnt_q   <= '0;
            idx_q   <= idx_q + 2'd1;
            an_q    <= AN_OFF;
            nib_q   <= BCD_BLANK;
            dpn_q   <= 1'b1;
            // Frame boundary: a same-cycle load wins over the stale pending copy.
            if (idx_q == 2'd3) begin
              tick_q   <= 1'b1;
              act_q    <= load ? digits_in : pend_q;
              act_dp_q <= load ? dp_in : pend_dp_q;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_BLANK;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  bcd_to_sevseg u_dec (
    .bcd_i (nib_q),
    .seg_o (segN)
  );

  assign anN        = an_q;
  assign dpN        = dpn_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_sevseg_scan_ctrl.sv
// Self-checking bench for sevseg_scan_ctrl (SHOW_CYC=4, BLANK_CYC=2, frame = 24 cycles).
module tb_sevseg_scan_ctrl;

  localparam int FRAME = 24;
  localparam int DIGIT = 6;
  localparam int BLANK = 2;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       tick;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic        load;
  logic [3:0]  anN;
  logic [6:0]  segN;
  logic        dpN;
  logic        frame_tick;

  int          nTests;
  int          nFail;
  int          cyc;
  logic [15:0] pendModel;
  logic [3:0]  pendDpModel;
  logic [15:0] actModel;
  logic [3:0]  actDpModel;
  exp_t        e;

  sevseg_scan_ctrl #(
    .SHOW_CYC  (4),
    .BLANK_CYC (2),
    .CNT_W     (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .load       (load),
    .anN        (anN),
    .segN       (segN),
    .dpN        (dpN),
    .frame_tick (frame_tick)
  );

  // Free-running 10 ns clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference segment patterns for each decimal digit; anything else is dark.
  function automatic logic [6:0] segOf(input logic [3:0] n);
    case (n)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Expected pins from the cycle position within the frame and the active value.
  function automatic exp_t modelOut();
    exp_t r;
    int pos, dig, ph;
    logic [3:0] nib;
    pos    = cyc % FRAME;
    dig    = pos / DIGIT;
    ph     = pos % DIGIT;
    r.tick = (cyc > 0) && (pos == 0);
    if (ph < BLANK) begin
      r.an  = 4'b1111;
      r.seg = 7'b1111111;
      r.dp  = 1'b1;
    end else begin
      r.an = 4'b1111 & ~(4'(1) << dig);
      nib  = actModel[dig*4 +: 4];
`ifdef LEADING_ZERO_BLANK_EN
      if (dig > 0 && (actModel >> (4*dig)) == 16'd0) nib = 4'hF;
`endif
      r.seg = segOf(nib);
      r.dp  = ~actDpModel[dig];
    end
    return r;
  endfunction

  task automatic modelReset();
    cyc         = 0;
    pendModel   = 16'hFFFF;
    pendDpModel = 4'b0000;
    actModel    = 16'hFFFF;
    actDpModel  = 4'b0000;
  endtask

  // Drive one cycle of inputs, advance the model across the edge, settle 1 ns.
  task automatic applyStimulus(input logic ld, input logic [15:0] d, input logic [3:0] p);
    load      = ld;
    digits_in = d;
    dp_in     = p;
    @(posedge clk);
    if (cyc % FRAME == FRAME - 1) begin
      actModel   = ld ? d : pendModel;
      actDpModel = ld ? p : pendDpModel;
    end
    if (ld) begin
      pendModel   = d;
      pendDpModel = p;
    end
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    load = 1'b0; digits_in = 16'h0000; dp_in = 4'b0000;
    #1 rst_n = 1'b0;
    #2;
    nTests++;
    if (anN !== 4'b1111 || segN !== 7'b1111111 || dpN !== 1'b1 || frame_tick !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL reset_async got an=%b seg=%b dp=%b tick=%b want an=1111 seg=1111111 dp=1 tick=0",
               anN, segN, dpN, frame_tick);
    end
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b1;
    modelReset();
    for (int i = 0; i < 30; i++) begin
      e = modelOut();
      nTests++;
      if (anN !== e.an || segN !== e.seg || dpN !== e.dp || frame_tick !== e.tick) begin
        nFail++;
        $display("[TB] FAIL reset_idle cyc=%0d got an=%b seg=%b dp=%b tick=%b want an=%b seg=%b dp=%b tick=%b",
                 cyc, anN, segN, dpN, frame_tick, e.an, e.seg, e.dp, e.tick);
      end
      applyStimulus(1'b0, 16'h0000, 4'b0000);
    end
  endtask

  task automatic test_load_1234();
    applyStimulus(1'b1, 16'h1234, 4'b0100);
    for (int i = 0; i < 2*FRAME; i++) begin
      e = modelOut();
      nTests++;
      if (anN !== e.an || segN !== e.seg || dpN !== e.dp || frame_tick !== e.tick) begin
        nFail++;
        $display("[TB] FAIL load_1234 cyc=%0d got an=%b seg=%b dp=%b tick=%b want an=%b seg=%b dp=%b tick=%b",
                 cyc, anN, segN, dpN, frame_tick, e.an, e.seg, e.dp, e.tick);
      end
      if (actModel == 16'h1234 && cyc % FRAME == 2*DIGIT + BLANK) begin
        nTests++;
        if (segN !== 7'b0100100 || dpN !== 1'b0 || anN !== 4'b1011) begin
          nFail++;
          $display("[TB] FAIL digit2_dp got an=%b seg=%b dp=%b want an=1011 seg=0100100 dp=0",
                   anN, segN, dpN);
        end
      end
      applyStimulus(1'b0, 16'h0000, 4'b0000);
    end
  endtask

  task automatic test_mid_frame_load();
    for (int i = 0; i < FRAME && cyc % FRAME != DIGIT + BLANK + 1; i++)
      applyStimulus(1'b0, 16'h0000, 4'b0000);
    applyStimulus(1'b1, 16'h5678, 4'b0001);
    for (int i = 0; i < 2*FRAME; i++) begin
      e = modelOut();
      nTests++;
      if (anN !== e.an || segN !== e.seg || dpN !== e.dp || frame_tick !== e.tick) begin
        nFail++;
        $display("[TB] FAIL mid_frame_load cyc=%0d got an=%b seg=%b dp=%b tick=%b want an=%b seg=%b dp=%b tick=%b",
                 cyc, anN, segN, dpN, frame_tick, e.an, e.seg, e.dp, e.tick);
      end
      applyStimulus(1'b0, 16'h0000, 4'b0000);
    end
  endtask

  task automatic test_back_to_back();
    // Load during the frame_tick cycle, then again on the boundary edge itself.
    for (int i = 0; i < FRAME && cyc % FRAME != 0; i++)
      applyStimulus(1'b0, 16'h0000, 4'b0000);
    applyStimulus(1'b1, 16'h9999, 4'b0000);
    for (int i = 0; i < FRAME + FRAME - 2; i++) begin
      e = modelOut();
      nTests++;
      if (anN !== e.an || segN !== e.seg || dpN !== e.dp || frame_tick !== e.tick) begin
        nFail++;
        $display("[TB] FAIL load_on_tick cyc=%0d got an=%b seg=%b dp=%b tick=%b want an=%b seg=%b dp=%b tick=%b",
                 cyc, anN, segN, dpN, frame_tick, e.an, e.seg, e.dp, e.tick);
      end
      applyStimulus(1'b0, 16'h0000, 4'b0000);
    end
    for (int i = 0; i < FRAME && cyc % FRAME != FRAME - 1; i++)
      applyStimulus(1'b0, 16'h0000, 4'b0000);
    applyStimulus(1'b1, 16'h4321, 4'b1010);
    for (int i = 0; i < FRAME + 6; i++) begin
      e = modelOut();
      nTests++;
      if (anN !== e.an || segN !== e.seg || dpN !== e.dp || frame_tick !== e.tick) begin
        nFail++;
        $display("[TB] FAIL load_on_boundary cyc=%0d got an=%b seg=%b dp=%b tick=%b want an=%b seg=%b dp=%b tick=%b",
                 cyc, anN, segN, dpN, frame_tick, e.an, e.seg, e.dp, e.tick);
      end
      applyStimulus(1'b0, 16'h0000, 4'b0000);
    end
  endtask

  task automatic test_invalid_digit();
    applyStimulus(1'b1, 16'h00A7, 4'b0010);
    for (int i = 0; i < 2*FRAME; i++) begin
      e = modelOut();
      nTests++;
      if (anN !== e.an || segN !== e.seg || dpN !== e.dp || frame_tick !== e.tick) begin
        nFail++;
        $display("[TB] FAIL invalid_digit cyc=%0d got an=%b seg=%b dp=%b tick=%b want an=%b seg=%b dp=%b tick=%b",
                 cyc, anN, segN, dpN, frame_tick, e.an, e.seg, e.dp, e.tick);
      end
      applyStimulus(1'b0, 16'h0000, 4'b0000);
    end
  endtask

  task automatic test_random();
    logic ld;
    for (int i = 0; i < 10*FRAME; i++) begin
      e = modelOut();
      nTests++;
      if (anN !== e.an || segN !== e.seg || dpN !== e.dp || frame_tick !== e.tick) begin
        nFail++;
        $display("[TB] FAIL random cyc=%0d got an=%b seg=%b dp=%b tick=%b want an=%b seg=%b dp=%b tick=%b",
                 cyc, anN, segN, dpN, frame_tick, e.an, e.seg, e.dp, e.tick);
      end
      ld = (i >= 100 && i < 140) ? 1'b1 : ($urandom_range(0, 3) == 0);
      applyStimulus(ld, 16'($urandom), 4'($urandom));
    end
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i < FRAME && cyc % FRAME != 2*DIGIT + BLANK + 1; i++)
      applyStimulus(1'b0, 16'h0000, 4'b0000);
    #2 rst_n = 1'b0;
    #1;
    nTests++;
    if (anN !== 4'b1111 || segN !== 7'b1111111 || dpN !== 1'b1 || frame_tick !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL reset_midframe got an=%b seg=%b dp=%b tick=%b want an=1111 seg=1111111 dp=1 tick=0",
               anN, segN, dpN, frame_tick);
    end
    #1 rst_n = 1'b1;
    modelReset();
    for (int i = 0; i < FRAME + 6; i++) begin
      e = modelOut();
      nTests++;
      if (anN !== e.an || segN !== e.seg || dpN !== e.dp || frame_tick !== e.tick) begin
        nFail++;
        $display("[TB] FAIL after_reset cyc=%0d got an=%b seg=%b dp=%b tick=%b want an=%b seg=%b dp=%b tick=%b",
                 cyc, anN, segN, dpN, frame_tick, e.an, e.seg, e.dp, e.tick);
      end
      applyStimulus(1'b0, 16'h0000, 4'b0000);
    end
  endtask

  initial begin
    nTests = 0;
    nFail  = 0;
    modelReset();
    test_reset();
    test_load_1234();
    test_mid_frame_load();
    test_back_to_back();
    test_invalid_digit();
    test_random();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
